alu_operand_entry: RTL and testbench



---
 rtl/alu_operand_entry.sv | 113 +++++++++++
 tb/tb_alu_operand_entry.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_operand_entry.sv
// Operand entry front end for the sign-magnitude ALU: debounces the enter key and
// steps through A, B and opcode capture, holding the results on registered outputs.
module alu_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sw,
  input  logic [2:0] op_sw,
  input  logic       btn_raw,
  output logic [4:0] a,
  output logic [4:0] b,
  output logic [2:0] button,
  output logic       valid,
  output logic [1:0] stage
);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RUN = 2'd3
  } stage_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync_0, sync;
  logic        stable, stable_d;
  logic [15:0] cnt;
  logic        press;

  stage_t      state_q, state_d;
  logic [4:0]  a_d, b_d;
  logic [2:0]  button_d;
  logic        valid_d;

  // A minus-zero operand is folded to plus-zero so the ALU sees one zero.
  function automatic logic [4:0] canon(input logic [4:0] v);
    return (v == 5'b10000) ? 5'b00000 : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_0   <= 1'b0;
      sync     <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= 16'd0;
    end else begin
      sync_0   <= btn_raw;
      sync     <= sync_0;
      stable_d <= stable;
      if (sync == stable) begin
        cnt <= 16'd0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync;
        cnt    <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign press = stable & ~stable_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a;
    b_d      = b;
    button_d = button;
    valid_d  = 1'b0;
    if (press) begin
      unique case (state_q)
        S_A: begin
          a_d     = canon(sw);
          state_d = S_B;
        end
        S_B: begin
          b_d     = canon(sw);
          state_d = S_OP;
        end
        S_OP: begin
          button_d = op_sw;
          valid_d  = 1'b1;
          state_d  = S_RUN;
        end
        S_RUN: begin
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      a       <= 5'd0;
      b       <= 5'd0;
      button  <= 3'd0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      a       <= a_d;
      b       <= b_d;
      button  <= button_d;
      valid   <= valid_d;
    end
  end

  assign stage = state_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed bench for alu_operand_entry with DEBOUNCE_CYCLES = 4.
module tb_alu_operand_entry;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sw;
  logic [2:0] op_sw;
  logic       btn_raw;
  logic [4:0] a;
  logic [4:0] b;
  logic [2:0] button;
  logic       valid;
  logic [1:0] stage;

  int errors = 0;
  int checks = 0;
  int pulses;
  int first_edge;

  alu_operand_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .op_sw  (op_sw),
    .btn_raw(btn_raw),
    .a      (a),
    .b      (b),
    .button (button),
    .valid  (valid),
    .stage  (stage)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full key press: held N+4 edges, released N+4 edges; counts valid pulses.
  task automatic applyStimulus(input logic [4:0] sw_v, input logic [2:0] op_v,
                               output int n_pulse, output int edge_idx);
    @(negedge clk);
    sw      = sw_v;
    op_sw   = op_v;
    btn_raw = 1'b1;
    n_pulse  = 0;
    edge_idx = -1;
    for (int i = 0; i < 2 * N + 8; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        n_pulse++;
        if (edge_idx < 0) edge_idx = i + 1;
      end
      if (i == N + 3) btn_raw = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; sw = 5'd0; op_sw = 3'd0; btn_raw = 1'b0;
    #12;
    checkOutput("reset_a", 8'(a), 8'd0);
    checkOutput("reset_b", 8'(b), 8'd0);
    checkOutput("reset_button", 8'(button), 8'd0);
    checkOutput("reset_valid", 8'(valid), 8'd0);
    checkOutput("reset_stage", 8'(stage), 8'd0);
    @(negedge clk); rst = 1'b0;

    // Held key: capture lands exactly on edge N+3.
    @(negedge clk);
    sw = 5'b00111; btn_raw = 1'b1;
    repeat (N + 2) @(posedge clk);
    #1;
    checkOutput("stage_before_edge7", 8'(stage), 8'd0);
    @(posedge clk); #1;
    checkOutput("stage_at_edge7", 8'(stage), 8'd1);
    checkOutput("a_at_edge7", 8'(a), 8'd7);
    checkOutput("valid_after_a", 8'(valid), 8'd0);
    @(negedge clk); btn_raw = 1'b0; sw = 5'b01111;
    repeat (N + 4) @(posedge clk);
    #1;
    checkOutput("a_after_sw_change", 8'(a), 8'd7);

    // Bounce bursts of 3 high / 1 low must not advance the FSM.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); btn_raw = 1'b1;
      repeat (3) @(negedge clk);
      btn_raw = 1'b0;
    end
    repeat (N + 4) @(posedge clk);
    #1;
    checkOutput("bounce_stage", 8'(stage), 8'd1);
    checkOutput("bounce_b", 8'(b), 8'd0);

    applyStimulus(5'b10010, 3'd0, pulses, first_edge);
    checkOutput("b_captured", 8'(b), 8'b10010);
    checkOutput("stage_op", 8'(stage), 8'd2);
    checkOutput("no_valid_b", 8'(pulses), 8'd0);

    applyStimulus(5'b00000, 3'b001, pulses, first_edge);
    checkOutput("button_captured", 8'(button), 8'd1);
    checkOutput("valid_pulses", 8'(pulses), 8'd1);
    checkOutput("valid_edge", 8'(first_edge), 8'(N + 3));
    checkOutput("stage_run", 8'(stage), 8'd3);
    checkOutput("a_held", 8'(a), 8'd7);

    // Leave S_RUN with different switches; outputs must persist.
    applyStimulus(5'b00001, 3'b110, pulses, first_edge);
    checkOutput("stage_wrap", 8'(stage), 8'd0);
    checkOutput("a_keep", 8'(a), 8'd7);
    checkOutput("b_keep", 8'(b), 8'b10010);
    checkOutput("button_keep", 8'(button), 8'd1);
    checkOutput("no_valid_run", 8'(pulses), 8'd0);

    applyStimulus(5'b10000, 3'd0, pulses, first_edge);
    checkOutput("a_minus_zero", 8'(a), 8'd0);
    checkOutput("stage_after_mz", 8'(stage), 8'd1);

    applyStimulus(5'b10011, 3'd0, pulses, first_edge);
    checkOutput("b_second", 8'(b), 8'b10011);
    checkOutput("stage_op2", 8'(stage), 8'd2);

    // Asynchronous reset between clock edges while in S_OP.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("async_a", 8'(a), 8'd0);
    checkOutput("async_b", 8'(b), 8'd0);
    checkOutput("async_button", 8'(button), 8'd0);
    checkOutput("async_valid", 8'(valid), 8'd0);
    checkOutput("async_stage", 8'(stage), 8'd0);

    // Key held through reset release still yields one press.
    sw = 5'b01010; btn_raw = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
    checkOutput("held_reset_stage", 8'(stage), 8'd1);
    checkOutput("held_reset_a", 8'(a), 8'b01010);
    repeat (3 * N) @(posedge clk);
    #1;
    checkOutput("held_no_repeat", 8'(stage), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
